// File: rtl/asg_pkg.sv
// Shared definitions for the azimuth signal generator blocks: loader state encoding,
// statistics counter width and the stream word-count helper.
package asg_pkg;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StFull   = 2'd1,
    StResync = 2'd2
  } loader_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchronizer for an asynchronous level input followed by a registered
// rising-edge detector; pulse_o is high for exactly one clock per detected rise.
module trig_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= trig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/asg_sweep_loader.sv
// Assembles one sweep's range-bin mask from an AXI-Stream into a shadow register and swaps
// it into DATA on each radar trigger. Define ASG_LOADER_STATS_EN to build the error counters.
module asg_sweep_loader
  import asg_pkg::*;
#(
  parameter int unsigned SIZE   = 3200,
  parameter int unsigned WORD_W = 32
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RESETN,
  input  logic [WORD_W-1:0] S_TDATA,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  input  logic              S_TLAST,
  input  logic              TRIG,
  output logic [SIZE-1:0]   DATA,
  output logic              EN,
  output logic              ERR_UNDERRUN,
  output logic              ERR_LENGTH,
  output logic [CntW-1:0]   UNDERRUN_CNT,
  output logic [CntW-1:0]   LENGTH_ERR_CNT
);

  localparam int unsigned NWORDS = ceil_div(SIZE, WORD_W);
  localparam int unsigned IdxW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned ShW    = NWORDS * WORD_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  loader_state_e   state_q;
  logic [IdxW-1:0] idx_q;
  logic [ShW-1:0]  shadow_q;
  logic [SIZE-1:0] data_q;
  logic            en_q, tready_q, err_underrun_q, err_length_q;
  logic            trig_evt, beat, last_beat, underrun_hit, length_hit;

  trig_sync u_trig_sync (
    .clk_i   (SYS_CLK),
    .rst_ni  (SYS_RESETN),
    .trig_i  (TRIG),
    .pulse_o (trig_evt)
  );

  assign beat         = S_TVALID & tready_q;
  assign last_beat    = (idx_q == LastIdx);
  // A trigger that lands on the completing beat still finds no complete sweep.
  assign underrun_hit = trig_evt & (state_q != StFull);
  assign length_hit   = beat & (state_q == StFill) & (last_beat ^ S_TLAST);

  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      state_q        <= StFill;
      idx_q          <= '0;
      shadow_q       <= '0;
      data_q         <= '0;
      en_q           <= 1'b0;
      tready_q       <= 1'b0;
      err_underrun_q <= 1'b0;
      err_length_q   <= 1'b0;
    end else begin
      err_underrun_q <= underrun_hit;
      err_length_q   <= length_hit;
      if (state_q != StFull) tready_q <= 1'b1;

      if (trig_evt) begin
        if (state_q == StFull) begin
          data_q   <= shadow_q[SIZE-1:0];
          en_q     <= 1'b1;
          idx_q    <= '0;
          state_q  <= StFill;
          tready_q <= 1'b1;
        end else begin
          data_q <= '0;
          en_q   <= 1'b0;
        end
      end

      // tready_q is low in StFull, so beats only arrive in StFill or StResync.
      if (beat) begin
        case (state_q)
          StFill: begin
            shadow_q[idx_q*WORD_W +: WORD_W] <= S_TDATA;
            if (last_beat) begin
              idx_q <= '0;
              if (S_TLAST) begin
                state_q  <= StFull;
                tready_q <= 1'b0;
              end else begin
                state_q <= StResync;
              end
            end else if (S_TLAST) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StResync: begin
            if (S_TLAST) begin
              state_q <= StFill;
              idx_q   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ASG_LOADER_STATS_EN
  logic [CntW-1:0] underrun_cnt_q, length_cnt_q;

  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      underrun_cnt_q <= '0;
      length_cnt_q   <= '0;
    end else begin
      if (underrun_hit && (underrun_cnt_q != '1)) underrun_cnt_q <= underrun_cnt_q + 1'b1;
      if (length_hit && (length_cnt_q != '1)) length_cnt_q <= length_cnt_q + 1'b1;
    end
  end

  assign UNDERRUN_CNT   = underrun_cnt_q;
  assign LENGTH_ERR_CNT = length_cnt_q;
`else
  assign UNDERRUN_CNT   = '0;
  assign LENGTH_ERR_CNT = '0;
`endif

  assign S_TREADY     = tready_q;
  assign DATA         = data_q;
  assign EN           = en_q;
  assign ERR_UNDERRUN = err_underrun_q;
  assign ERR_LENGTH   = err_length_q;

endmodule
